polling_os_scheduler: RTL and testbench
=======================================

// Module: polling_os_scheduler
// PURPOSE
//  Training-set sequencer for the LTSSM Polling substate. Drives TS1 (Polling.Active)
//  and TS2 (Polling.Configuration) ordered-set requests to the lane TX framer.
//  Tracks per-lane consecutive RX ordered sets and flags the exit criteria consumed by
//  the polling FSM: TX minimum count met plus RX lock on every lane with a detected load.
// PARAMETERS
//  NUM_LANES        4     lanes tracked; width of lane vectors
//  ACTIVE_TX_MIN    1024  TS1 sets sent before active_done_o may assert
//  RX_CONSEC        8     consecutive qualifying RX sets per lane for RX lock
//  CFG_TX_AFTER     16    TS2 sets sent after first TS2 received before config_done_o
// PORTS
//  clk_i            in   1          clock
//  rst_i            in   1          reset, asynchronous, active-high
//  enable_i         in   1          polling_en; low forces IDLE and clears all state
//  phase_cfg_i      in   1          0 = Polling.Active, 1 = Polling.Configuration
//  lanes_active_i   in   NUM_LANES  lanes with detected receiver load; others ignored
//  os_tx_req_o      out  1          request to send one ordered set
//  os_tx_type_o     out  1          0 = TS1, 1 = TS2; valid while os_tx_req_o high
//  os_tx_ack_i      in   1          framer accepted one set this cycle (req & ack)
//  rx_os_valid_i    in   NUM_LANES  per-lane RX ordered set decoded this cycle
//  rx_os_type_i     in   NUM_LANES  per-lane RX type, 0 = TS1, 1 = TS2
//  rx_os_err_i      in   NUM_LANES  per-lane RX symbol/parity error this cycle
//  active_done_o    out  1          Polling.Active exit criteria met (level)
//  config_done_o    out  1          Polling.Configuration exit criteria met (level)
// BEHAVIOUR
//  - Reset: state IDLE; all counters 0; os_tx_req_o, os_tx_type_o, and both done outputs are 0.
//  - FSM states: IDLE, TX_TS1, TX_TS2. All outputs registered.
//    IDLE   -> TX_TS1 when enable_i & !phase_cfg_i.
//    IDLE   -> TX_TS2 when enable_i & phase_cfg_i.
//    TX_TS1 -> TX_TS2 when phase_cfg_i = 1. On this transition, clear the RX counters,
//      the cfg TX counter, and ts2_seen.
//    any    -> IDLE when enable_i = 0. Clear every counter and flag in the same edge.
//  - os_tx_req_o = 1 in TX_TS1 and TX_TS2; os_tx_type_o = (state == TX_TS2).
//    No gaps: req stays high across acks. One set is counted per cycle with req & ack.
//    The ack in the cycle of the TS1->TS2 transition counts as a TS1.
//  - tx_cnt: 11 bits, counts TS1 acks in TX_TS1, saturates at ACTIVE_TX_MIN.
//  - RX counters: one per lane, $clog2(RX_CONSEC+1) bits, saturate at RX_CONSEC.
//    TX_TS1: a valid TS1 or TS2 increments; err resets to 0.
//    TX_TS2: a valid TS2 increments; a valid TS1 or err resets to 0.
//    Inactive lanes: counter held at 0; the lane is treated as locked.
//    valid & err in the same cycle: err wins (reset).
//  - rx_lock = AND over lanes of (!lanes_active_i[l] | cnt[l] == RX_CONSEC).
//    lanes_active_i all zero -> rx_lock = 0 (no lanes, never done).
//  - ts2_seen: set in TX_TS2 on the first valid error-free TS2 on any active lane.
//    It is sticky until IDLE or re-entry into TX_TS2.
//    cfg_cnt: counts TS2 acks only while ts2_seen = 1, including an ack in the same
//    cycle ts2_seen sets. It saturates at CFG_TX_AFTER.
//  - active_done_o: registered; 1 in TX_TS1 when tx_cnt == ACTIVE_TX_MIN & rx_lock.
//    Visible the cycle after the completing ack or RX set. Deasserts if rx_lock drops.
//  - config_done_o: registered; 1 in TX_TS2 when cfg_cnt == CFG_TX_AFTER & rx_lock.
//  - Transmission continues after done is asserted, until enable_i falls.
//  - Asserting rst_i mid-sequence returns all outputs to reset values immediately.
// TESTING
//  1. Active, ack every cycle, lanes 4'b1111 each receiving TS1 every 16 cycles
//     -> active_done_o rises 1 cycle after the 1024th ack; not earlier.
//  2. Active, lane 2 gets an err after 7 TS1s -> lane 2 restarts at 0;
//     done is delayed until lane 2 collects 8 fresh sets.
//  3. lanes_active_i = 4'b0011, lanes 2/3 silent -> done after lanes 0/1 lock
//     and 1024 TX; lanes_active_i = 0 -> done never asserts.
//  4. Switch phase_cfg_i to 1 after active_done_o -> os_tx_type_o = 1 next cycle;
//     config_done_o rises 1 cycle after the 16th ack counted from the first RX TS2,
//     provided all lanes have received 8 TS2.
//  5. In Configuration, lane 1 receives TS1 after 5 TS2s -> its count resets to 0;
//     config_done_o is held off until 8 further TS2s arrive on lane 1.
//  6. Drop enable_i or pulse rst_i mid TX_TS2 -> req, type, and done go to 0;
//     re-enable in Active restarts at tx_cnt = 0.

Source files
------------

// File: rtl/polling_os_scheduler.sv
// LTSSM Polling training-set sequencer: issues TS1/TS2 requests to the TX framer,
// tracks per-lane consecutive RX ordered sets and flags Polling.Active/Configuration exit.
module polling_os_scheduler #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned ACTIVE_TX_MIN = 1024,
    parameter int unsigned RX_CONSEC     = 8,
    parameter int unsigned CFG_TX_AFTER  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 phase_cfg_i,
    input  logic [NUM_LANES-1:0] lanes_active_i,
    output logic                 os_tx_req_o,
    output logic                 os_tx_type_o,
    input  logic                 os_tx_ack_i,
    input  logic [NUM_LANES-1:0] rx_os_valid_i,
    input  logic [NUM_LANES-1:0] rx_os_type_i,
    input  logic [NUM_LANES-1:0] rx_os_err_i,
    output logic                 active_done_o,
    output logic                 config_done_o
);

    localparam int unsigned TXW = $clog2(ACTIVE_TX_MIN + 1);
    localparam int unsigned RXW = $clog2(RX_CONSEC + 1);
    localparam int unsigned CFW = $clog2(CFG_TX_AFTER + 1);

    typedef enum logic [1:0] {IDLE, TX_TS1, TX_TS2} state_e;

    state_e                        state_q, state_d;
    logic [TXW-1:0]                tx_cnt_q, tx_cnt_d;
    logic [NUM_LANES-1:0][RXW-1:0] rx_cnt_q, rx_cnt_d;
    logic [CFW-1:0]                cfg_cnt_q, cfg_cnt_d;
    logic                          ts2_seen_q, ts2_seen_d;
    logic                          req_q, req_d;
    logic                          type_q, type_d;
    logic                          act_done_q, act_done_d;
    logic                          cfg_done_q, cfg_done_d;
    logic                          tx_fire;
    logic                          ts2_hit;
    logic                          rx_lock;

    assign tx_fire = req_q & os_tx_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            cfg_cnt_q  <= '0;
            ts2_seen_q <= 1'b0;
            req_q      <= 1'b0;
            type_q     <= 1'b0;
            act_done_q <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            cfg_cnt_q  <= cfg_cnt_d;
            ts2_seen_q <= ts2_seen_d;
            req_q      <= req_d;
            type_q     <= type_d;
            act_done_q <= act_done_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = phase_cfg_i ? TX_TS2 : TX_TS1;
                TX_TS1:  if (phase_cfg_i) state_d = TX_TS2;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        cfg_cnt_d  = cfg_cnt_q;
        ts2_seen_d = ts2_seen_q;
        ts2_hit    = 1'b0;

        if (state_q == TX_TS1 && tx_fire && tx_cnt_q != TXW'(ACTIVE_TX_MIN))
            tx_cnt_d = tx_cnt_q + TXW'(1);

        // Error beats valid; in Configuration a TS1 breaks the consecutive TS2 run.
        if (state_q != IDLE) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                if (!lanes_active_i[l] || rx_os_err_i[l]) begin
                    rx_cnt_d[l] = '0;
                end else if (rx_os_valid_i[l]) begin
                    if (state_q == TX_TS2 && !rx_os_type_i[l])
                        rx_cnt_d[l] = '0;
                    else if (rx_cnt_q[l] != RXW'(RX_CONSEC))
                        rx_cnt_d[l] = rx_cnt_q[l] + RXW'(1);
                    if (state_q == TX_TS2 && rx_os_type_i[l])
                        ts2_hit = 1'b1;
                end
            end
        end

        if (state_q == TX_TS2) begin
            ts2_seen_d = ts2_seen_q | ts2_hit;
            if (tx_fire && ts2_seen_d && cfg_cnt_q != CFW'(CFG_TX_AFTER))
                cfg_cnt_d = cfg_cnt_q + CFW'(1);
        end

        if (state_q == TX_TS1 && state_d == TX_TS2) begin
            rx_cnt_d   = '0;
            cfg_cnt_d  = '0;
            ts2_seen_d = 1'b0;
        end

        if (!enable_i) begin
            tx_cnt_d   = '0;
            rx_cnt_d   = '0;
            cfg_cnt_d  = '0;
            ts2_seen_d = 1'b0;
        end
    end

    always_comb begin
        rx_lock = |lanes_active_i;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (lanes_active_i[l] && rx_cnt_d[l] != RXW'(RX_CONSEC))
                rx_lock = 1'b0;
        end
        req_d      = (state_d != IDLE);
        type_d     = (state_d == TX_TS2);
        act_done_d = (state_d == TX_TS1) && (tx_cnt_d == TXW'(ACTIVE_TX_MIN)) && rx_lock;
        cfg_done_d = (state_d == TX_TS2) && (cfg_cnt_d == CFW'(CFG_TX_AFTER)) && rx_lock;
    end

    assign os_tx_req_o   = req_q;
    assign os_tx_type_o  = type_q;
    assign active_done_o = act_done_q;
    assign config_done_o = cfg_done_q;

endmodule

// File: tb/tb_polling_os_scheduler.sv
// Bench for polling_os_scheduler: directed scenarios plus random traffic, each cycle
// compared against a counter-based reference model of the polling exit rules.
module tb_polling_os_scheduler;

    localparam int NL     = 4;
    localparam int TX_MIN = 1024;
    localparam int RX_N   = 8;
    localparam int CFG_N  = 16;

    logic          clk = 1'b0;
    logic          rst, en, ph, ack;
    logic [NL-1:0] act, vld, typ, err;
    logic          os_tx_req_o, os_tx_type_o, active_done_o, config_done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_acks = 0;

    // reference model: 0 = not polling, 1 = sending TS1, 2 = sending TS2
    int m_mode, m_tx, m_cfg;
    int m_rx[NL];
    bit m_seen;
    logic exp_req, exp_type, exp_ad, exp_cd;

    always #5 clk = ~clk;

    polling_os_scheduler #(
        .NUM_LANES(NL), .ACTIVE_TX_MIN(TX_MIN), .RX_CONSEC(RX_N), .CFG_TX_AFTER(CFG_N)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .phase_cfg_i(ph),
        .lanes_active_i(act), .os_tx_req_o(os_tx_req_o), .os_tx_type_o(os_tx_type_o),
        .os_tx_ack_i(ack), .rx_os_valid_i(vld), .rx_os_type_i(typ), .rx_os_err_i(err),
        .active_done_o(active_done_o), .config_done_o(config_done_o)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    function automatic void model_outputs();
        bit lock;
        lock = (act != '0);
        for (int l = 0; l < NL; l++)
            if (act[l] && m_rx[l] < RX_N) lock = 0;
        exp_req  = (m_mode != 0);
        exp_type = (m_mode == 2);
        exp_ad   = (m_mode == 1) && (m_tx >= TX_MIN) && lock;
        exp_cd   = (m_mode == 2) && (m_cfg >= CFG_N) && lock;
    endfunction

    function automatic void model_clear();
        m_mode = 0; m_tx = 0; m_cfg = 0; m_seen = 0;
        for (int l = 0; l < NL; l++) m_rx[l] = 0;
        exp_req = 0; exp_type = 0; exp_ad = 0; exp_cd = 0;
    endfunction

    function automatic void model_step();
        bit hit;
        hit = 0;
        if (rst || !en) begin
            model_clear();
            return;
        end
        if (m_mode == 0) begin
            m_mode = ph ? 2 : 1;
        end else if (m_mode == 1) begin
            if (ack && m_tx < TX_MIN) m_tx++;
            if (ph) begin
                m_mode = 2; m_cfg = 0; m_seen = 0;
                for (int l = 0; l < NL; l++) m_rx[l] = 0;
            end else begin
                for (int l = 0; l < NL; l++)
                    if (!act[l] || err[l]) m_rx[l] = 0;
                    else if (vld[l] && m_rx[l] < RX_N) m_rx[l]++;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (!act[l] || err[l]) m_rx[l] = 0;
                else if (vld[l] && !typ[l]) m_rx[l] = 0;
                else if (vld[l]) begin
                    hit = 1;
                    if (m_rx[l] < RX_N) m_rx[l]++;
                end
            end
            if (hit) m_seen = 1;
            if (ack && m_seen && m_cfg < CFG_N) m_cfg++;
        end
        model_outputs();
    endfunction

    task automatic check_outputs(input string pfx);
        chk({pfx, "_req"},   os_tx_req_o,   exp_req);
        chk({pfx, "_type"},  os_tx_type_o,  exp_type);
        chk({pfx, "_adone"}, active_done_o, exp_ad);
        chk({pfx, "_cdone"}, config_done_o, exp_cd);
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_mode != 0 && ack && !rst && en) n_acks++;
        model_step();
        cyc++;
        #1;
        check_outputs("cyc");
    endtask

    task automatic run(input int n, input int ack_pct, input int per,
                       input logic [NL-1:0] tmask, input int err_pct,
                       input logic [NL-1:0] silent);
        for (int c = 0; c < n; c++) begin
            ack = ($urandom_range(0, 99) < ack_pct);
            for (int l = 0; l < NL; l++) begin
                vld[l] = (per > 0) && !silent[l] && (((c + l) % per) == 0);
                typ[l] = tmask[l];
                err[l] = (err_pct > 0) && ($urandom_range(0, 99) < err_pct);
            end
            tick();
        end
        vld = '0; err = '0;
    endtask

    task automatic disable_and_check();
        en = 1'b0; ph = 1'b0; ack = 1'b0;
        tick();
    endtask

    initial begin
        int rise, at_full, sets1;
        rst = 1'b1; en = 1'b0; ph = 1'b0; ack = 1'b0;
        act = '1; vld = '0; typ = '0; err = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // 1: TS1 every 16 cycles on all lanes, ack every cycle; done edge vs 1024th ack
        en = 1'b1; act = 4'b1111;
        n_acks = 0; rise = -1; at_full = -1;
        for (int c = 0; c < 1200; c++) begin
            ack = 1'b1;
            vld = ((c % 16) == 0) ? 4'b1111 : 4'b0000;
            tick();
            if (n_acks == TX_MIN && at_full < 0) at_full = cyc;
            if (active_done_o && rise < 0) rise = cyc;
        end
        chk("t1_rise_after_1024th_ack", (rise == at_full) && (at_full > 0), 1'b1);
        disable_and_check();

        // 2: slow TS1 stream, lane 2 errors after its 7th set and must recollect 8
        en = 1'b1; act = 4'b1111; ack = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            vld = ((c % 120) == 0 && c > 0) ? 4'b1111 : 4'b0000;
            err = (c == 900) ? 4'b0100 : 4'b0000;
            tick();
            if (c == 1700) chk("t2_held_off", active_done_o, 1'b0);
        end
        chk("t2_done_after_relock", active_done_o, 1'b1);
        err = '0;
        disable_and_check();

        // 3a: only lanes 0/1 active, lanes 2/3 silent
        en = 1'b1; act = 4'b0011;
        run(1500, 80, 16, 4'b0000, 0, 4'b1100);
        chk("t3_two_lanes_done", active_done_o, 1'b1);
        disable_and_check();

        // 3b: no active lanes, never done
        en = 1'b1; act = 4'b0000;
        run(1200, 100, 8, 4'b0000, 0, 4'b0000);
        chk("t3_no_lanes_never", active_done_o, 1'b0);
        disable_and_check();

        // 4/5: reach Active done, go to Configuration, lane 1 sees TS1 after 5 TS2s
        en = 1'b1; act = 4'b1111;
        run(1100, 100, 16, 4'b0000, 0, 4'b0000);
        chk("t4_active_done", active_done_o, 1'b1);
        ph = 1'b1; ack = 1'b1; vld = '0;
        tick();
        chk("t4_type_next_cycle", os_tx_type_o, 1'b1);
        sets1 = 0;
        for (int c = 0; c < 200; c++) begin
            ack = ($urandom_range(0, 3) != 0);
            vld = ((c % 6) == 0) ? 4'b1111 : 4'b0000;
            typ = 4'b1111;
            if (vld[1]) begin
                sets1++;
                if (sets1 == 6) typ[1] = 1'b0;
            end
            tick();
            if (sets1 == 12 && vld[1]) chk("t5_held_off", config_done_o, 1'b0);
        end
        chk("t5_config_done", config_done_o, 1'b1);
        vld = '0;

        // 6: drop enable mid TS2, then async reset mid TS2, then re-enter Active
        disable_and_check();
        chk("t6_req_low", os_tx_req_o, 1'b0);
        en = 1'b1; ph = 1'b1;
        run(60, 90, 3, 4'b1111, 0, 4'b0000);
        #3 rst = 1'b1;
        #1 model_clear();
        check_outputs("rst_async");
        #1 rst = 1'b0;
        ph = 1'b0;
        run(30, 100, 4, 4'b0000, 0, 4'b0000);
        chk("t6_restart_not_done", active_done_o, 1'b0);
        disable_and_check();

        // random soak with enable/phase/lane changes and errors
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) ph = ~ph;
            if ($urandom_range(0, 299) == 0) act = NL'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            vld = NL'($urandom);
            typ = NL'($urandom) | NL'($urandom);
            err = ($urandom_range(0, 19) == 0) ? NL'($urandom) : '0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
